// File: rtl/ucdp_sync_hs_pkg.sv
// Shared types for the 4-phase req/ack clock-domain-crossing handshake.
// The state encoding is shared by the tx and rx sides of the handshake.
package ucdp_sync_hs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } sync_hs_state_t;

  // A transfer is in progress in every state except IDLE.
  function automatic logic hs_busy(sync_hs_state_t state);
    return state != IDLE;
  endfunction

endpackage

// File: rtl/ucdp_sync_hs_acksync.sv
// Two-flop level synchronizer for the returning handshake acknowledge.
// Simulation builds may add one cycle of random latency to mimic metastability resolution.
module ucdp_sync_hs_acksync (
  input  logic main_clk_i,
  input  logic main_rst_i,
  input  logic d_i,
  output logic q_o
);

  logic d_sel;
  logic s1_q;
  logic s2_q;

`ifdef SIM
`ifndef CLD_SYNC_NO_JITTER
  logic d_dly;
  logic jit;

  always_ff @(posedge main_clk_i) begin
    d_dly <= d_i;
    jit   <= 1'($urandom_range(0, 1));
  end

  assign d_sel = jit ? d_dly : d_i;
`else
  assign d_sel = d_i;
`endif
`else
  assign d_sel = d_i;
`endif

  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_sel;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/ucdp_sync_hs_tx.sv
// Source-domain transmitter of a 4-phase req/ack handshake: holds one word stable
// on tx_data_o while tx_req_o is raised, and completes all four phases before the next word.
module ucdp_sync_hs_tx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             main_clk_i,
  input  logic             main_rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             tx_req_o,
  output logic [WIDTH-1:0] tx_data_o,
  input  logic             tx_ack_i,
  output logic             busy_o,
  output logic             done_o
);
  import ucdp_sync_hs_pkg::*;

  sync_hs_state_t state;
  logic           ack_s;

  ucdp_sync_hs_acksync u_acksync (
    .main_clk_i (main_clk_i),
    .main_rst_i (main_rst_i),
    .d_i        (tx_ack_i),
    .q_o        (ack_s)
  );

  // A stale high ack in IDLE blocks acceptance until the peer has released it.
  assign ready_o = (state == IDLE) && !ack_s;
  assign busy_o  = hs_busy(state);

  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      state     <= IDLE;
      tx_req_o  <= 1'b0;
      tx_data_o <= '0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i && ready_o) begin
            tx_data_o <= data_i;
            tx_req_o  <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            tx_req_o <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (!ack_s) begin
            done_o <= 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          tx_req_o <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
